// File: rtl/stream_width_packer.sv
// Packs a narrow valid/ready byte-lane stream into full-width FIFO words with lane-count and packet-last sideband.
// Optional idle-timeout flush of partial words is enabled by defining PACKER_FLUSH_TIMEOUT_EN.
module stream_width_packer #(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned OUT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [IN_WIDTH-1:0]                       in_data,
    input  logic                                      in_last,
    input  logic                                      fifo_full,
    output logic                                      fifo_wr_en,
    output logic [OUT_WIDTH-1:0]                      fifo_wr_data,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]       fifo_wr_lanes,
    output logic                                      fifo_wr_last
);

    localparam int unsigned RATIO  = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = $clog2(RATIO) + 1;
    localparam int unsigned CNT_W  = $clog2(RATIO);

    // Reject geometries the lane counter cannot represent
    generate
        if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * IN_WIDTH != OUT_WIDTH
            || TIMEOUT_CYCLES == 0) begin : g_cfg_err
            $error("stream_width_packer: unsupported IN_WIDTH/OUT_WIDTH/TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_n;
    logic [OUT_WIDTH-1:0]   r_data;
    logic [OUT_WIDTH-1:0]   w_data_n;
    logic [LANE_W-1:0]      r_lanes;
    logic [LANE_W-1:0]      w_lanes_n;
    logic                   r_last;
    logic                   w_last_n;
    logic                   w_accept;
    logic                   w_write;

`ifdef PACKER_FLUSH_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0]      r_idle;
    logic [IDLE_W-1:0]      w_idle_n;
`endif

    assign in_ready      = (r_state == FILL) || ((r_state == HOLD) && !fifo_full);
    assign w_accept      = in_valid && in_ready;
    assign w_write       = (r_state == HOLD) && !fifo_full;

    assign fifo_wr_en    = (r_state == HOLD);
    assign fifo_wr_data  = r_data;
    assign fifo_wr_lanes = r_lanes;
    assign fifo_wr_last  = r_last;

    // State and holding-register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_lanes <= '0;
            r_last  <= 1'b0;
`ifdef PACKER_FLUSH_TIMEOUT_EN
            r_idle  <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_data  <= w_data_n;
            r_lanes <= w_lanes_n;
            r_last  <= w_last_n;
`ifdef PACKER_FLUSH_TIMEOUT_EN
            r_idle  <= w_idle_n;
`endif
        end
    end

    // Next-state: FILL gathers beats little-endian, HOLD presents the word until the FIFO takes it
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_data_n  = r_data;
        w_lanes_n = r_lanes;
        w_last_n  = r_last;
`ifdef PACKER_FLUSH_TIMEOUT_EN
        w_idle_n  = r_idle;
`endif

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    for (int k = 0; k < int'(RATIO); k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            w_data_n[k*IN_WIDTH +: IN_WIDTH] = in_data;
                        end
                    end
`ifdef PACKER_FLUSH_TIMEOUT_EN
                    w_idle_n = '0;
`endif
                    if (r_cnt == CNT_W'(RATIO - 1) || in_last) begin
                        w_state_n = HOLD;
                        w_lanes_n = LANE_W'(r_cnt) + LANE_W'(1);
                        w_last_n  = in_last;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n   = r_cnt + CNT_W'(1);
                    end
                end
`ifdef PACKER_FLUSH_TIMEOUT_EN
                // The idle cycle that brings the count to TIMEOUT_CYCLES flushes the partial word
                else if (r_cnt != '0) begin
                    if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_n = HOLD;
                        w_lanes_n = LANE_W'(r_cnt);
                        w_last_n  = 1'b0;
                        w_cnt_n   = '0;
                        w_idle_n  = '0;
                    end else begin
                        w_idle_n  = r_idle + IDLE_W'(1);
                    end
                end
`endif
            end

            HOLD: begin
                if (w_write) begin
                    w_state_n = FILL;
                    w_data_n  = '0;
                    w_lanes_n = '0;
                    w_last_n  = 1'b0;
                    w_cnt_n   = '0;
                    // A beat arriving with the write starts the next word in lane 0 without a bubble
                    if (in_valid) begin
                        w_data_n[IN_WIDTH-1:0] = in_data;
                        if (in_last) begin
                            w_state_n = HOLD;
                            w_lanes_n = LANE_W'(1);
                            w_last_n  = 1'b1;
                        end else begin
                            w_cnt_n   = CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_n = FILL;
            end
        endcase
    end

endmodule
